// File: rtl/fa_pkg.sv
// Shared types and constants for full-adder response checkers.
package fa_pkg;

  localparam int FA_VEC_MAX = 8;
  localparam int FA_ABC_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fa_state_e;

  function automatic logic [3:0] fa_popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < 8; k++) begin
      n = n + {3'd0, v[k]};
    end
    return n;
  endfunction

endpackage

// File: rtl/fa_ref_model.sv
// Combinational golden full adder; abc_i = {a, b, cin}.
module fa_ref_model
  import fa_pkg::*;
(
  input  logic [FA_ABC_W-1:0] abc_i,
  output logic                exp_s_o,
  output logic                exp_cout_o
);

  logic a, b, cin;

  assign a   = abc_i[2];
  assign b   = abc_i[1];
  assign cin = abc_i[0];

  assign exp_s_o    = a ^ b ^ cin;
  assign exp_cout_o = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/fa_resp_checker.sv
// Checks a full-adder DUT against the reference model over one run of NUM_VEC
// accepted vectors, reporting error count, first failing vector and coverage.
module fa_resp_checker
  import fa_pkg::*;
#(
  parameter int NUM_VEC = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                vec_valid,
  input  logic [FA_ABC_W-1:0] vec_abc,
  input  logic                s_dut,
  input  logic                cout_dut,
  output logic                vec_ready,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [3:0]          err_count,
  output logic [FA_ABC_W-1:0] first_err_abc,
  output logic [7:0]          coverage
);

  localparam logic [3:0] LAST_CNT  = 4'(NUM_VEC - 1);
  localparam logic [3:0] NUM_VEC_W = 4'(NUM_VEC);
  localparam logic [3:0] ERR_MAX   = 4'(FA_VEC_MAX);

  // Reset asserts immediately, releases two edges later.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  fa_state_e           state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [3:0]          err_q, err_d;
  logic [FA_ABC_W-1:0] first_q, first_d;
  logic [7:0]          cov_q, cov_d;
  logic                pass_q, pass_d;

  logic exp_s, exp_cout;
  logic accept, mism;

  fa_ref_model u_ref (
    .abc_i      (vec_abc),
    .exp_s_o    (exp_s),
    .exp_cout_o (exp_cout)
  );

  assign accept = vec_valid && (state_q == RUN);
  assign mism   = (s_dut != exp_s) || (cout_dut != exp_cout);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    first_d = first_q;
    cov_d   = cov_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = 4'd0;
          err_d   = 4'd0;
          first_d = '0;
          cov_d   = 8'd0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        if (accept) begin
          cnt_d = cnt_q + 4'd1;
          cov_d = cov_q | (8'd1 << vec_abc);
          if (mism && (err_q < ERR_MAX)) begin
            err_d = err_q + 4'd1;
          end
          if (mism && (err_q == 4'd0)) begin
            first_d = vec_abc;
          end
          // Verdict uses the post-update error count and coverage.
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
            pass_d  = (err_d == 4'd0) && (fa_popcount8(cov_d) >= NUM_VEC_W);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 4'd0;
      first_q <= '0;
      cov_q   <= 8'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      first_q <= first_d;
      cov_q   <= cov_d;
      pass_q  <= pass_d;
    end
  end

  assign vec_ready     = (state_q == RUN);
  assign busy          = (state_q == RUN);
  assign done          = (state_q == DONE);
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_abc = first_q;
  assign coverage      = cov_q;

endmodule

// File: tb/tb_fa_resp_checker.sv
// Directed bench for fa_resp_checker with hand-computed expectations.
module tb_fa_resp_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       vec_valid = 1'b0;
  logic [2:0] vec_abc = 3'd0;
  logic       s_dut = 1'b0;
  logic       cout_dut = 1'b0;
  logic       vec_ready, busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] first_err_abc;
  logic [7:0] coverage;

  int total = 0;
  int bad   = 0;

  fa_resp_checker #(.NUM_VEC(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .vec_valid     (vec_valid),
    .vec_abc       (vec_abc),
    .s_dut         (s_dut),
    .cout_dut      (cout_dut),
    .vec_ready     (vec_ready),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_abc (first_err_abc),
    .coverage      (coverage)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic fa_s(input logic [2:0] v);
    return v[2] ^ v[1] ^ v[0];
  endfunction

  function automatic logic fa_c(input logic [2:0] v);
    return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] abc, input logic flip_s, input logic flip_c);
    vec_valid = 1'b1;
    vec_abc   = abc;
    s_dut     = fa_s(abc) ^ flip_s;
    cout_dut  = fa_c(abc) ^ flip_c;
    tick();
    vec_valid = 1'b0;
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  logic [7:0] cov_m;
  logic [2:0] r_abc;

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_ready", {7'd0, vec_ready}, 8'd0);
    chk("rst_busy",  {7'd0, busy}, 8'd0);
    chk("rst_done",  {7'd0, done}, 8'd0);
    chk("rst_pass",  {7'd0, pass}, 8'd0);
    chk("rst_err",   {4'd0, err_count}, 8'd0);
    chk("rst_cov",   coverage, 8'd0);
    release_reset();
    chk("idle_busy", {7'd0, busy}, 8'd0);

    // Full correct run 0..7
    do_start();
    chk("t1_busy",  {7'd0, busy}, 8'd1);
    chk("t1_ready", {7'd0, vec_ready}, 8'd1);
    for (int i = 0; i < 8; i++) begin
      send(3'(i), 1'b0, 1'b0);
      if (i == 6) chk("t1_notdone7", {7'd0, done}, 8'd0);
    end
    chk("t1_done",  {7'd0, done}, 8'd1);
    chk("t1_pass",  {7'd0, pass}, 8'd1);
    chk("t1_err",   {4'd0, err_count}, 8'd0);
    chk("t1_cov",   coverage, 8'hFF);
    chk("t1_ready_drop", {7'd0, vec_ready}, 8'd0);
    tick();
    chk("t1_hold_pass", {7'd0, pass}, 8'd1);

    // Restart from DONE; sum wrong on abc 3 and 5
    do_start();
    chk("t2_done_fall", {7'd0, done}, 8'd0);
    chk("t2_busy_rise", {7'd0, busy}, 8'd1);
    chk("t2_cov_clr",   coverage, 8'd0);
    chk("t2_pass_clr",  {7'd0, pass}, 8'd0);
    for (int i = 0; i < 8; i++) send(3'(i), (i == 3) || (i == 5), 1'b0);
    chk("t2_done",  {7'd0, done}, 8'd1);
    chk("t2_err",   {4'd0, err_count}, 8'd2);
    chk("t2_first", {5'd0, first_err_abc}, 8'd3);
    chk("t2_pass",  {7'd0, pass}, 8'd0);

    // valid toggling, random abc; invalid cycles carry wrong results
    do_start();
    cov_m = 8'd0;
    for (int i = 0; i < 16; i++) begin
      r_abc     = 3'($urandom_range(0, 7));
      vec_valid = (i % 2 == 0);
      vec_abc   = r_abc;
      s_dut     = fa_s(r_abc) ^ !vec_valid;
      cout_dut  = fa_c(r_abc) ^ !vec_valid;
      if (vec_valid) cov_m = cov_m | (8'd1 << r_abc);
      tick();
      if (i == 13) chk("t3_notdone7", {7'd0, done}, 8'd0);
      if (i == 14) chk("t3_done8",    {7'd0, done}, 8'd1);
    end
    vec_valid = 1'b0;
    chk("t3_err",  {4'd0, err_count}, 8'd0);
    chk("t3_cov",  coverage, cov_m);
    chk("t3_pass", {7'd0, pass}, {7'd0, cov_m == 8'hFF});

    // Duplicate vector leaves coverage short
    do_start();
    send(3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) send(3'(i), 1'b0, 1'b0);
    chk("t4_done", {7'd0, done}, 8'd1);
    chk("t4_err",  {4'd0, err_count}, 8'd0);
    chk("t4_cov",  coverage, 8'h7F);
    chk("t4_pass", {7'd0, pass}, 8'd0);

    // Reset mid-run after 4 accepts (one mismatching)
    do_start();
    for (int i = 0; i < 4; i++) send(3'(i), 1'b0, i == 2);
    chk("t5_pre_err", {4'd0, err_count}, 8'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_busy",  {7'd0, busy}, 8'd0);
    chk("t5_ready", {7'd0, vec_ready}, 8'd0);
    chk("t5_done",  {7'd0, done}, 8'd0);
    chk("t5_err",   {4'd0, err_count}, 8'd0);
    chk("t5_first", {5'd0, first_err_abc}, 8'd0);
    chk("t5_cov",   coverage, 8'd0);
    tick();
    release_reset();
    do_start();
    for (int i = 7; i >= 0; i--) send(3'(i), 1'b0, 1'b0);
    chk("t5_rerun_pass", {7'd0, pass}, 8'd1);
    chk("t5_rerun_cov",  coverage, 8'hFF);

    // start held high through RUN into DONE; error on abc 6
    start = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      send(3'(i), i == 6, 1'b0);
      if (i == 3) chk("t6_cov_mid", coverage, 8'h0F);
      if (i == 3) chk("t6_busy_mid", {7'd0, busy}, 8'd1);
    end
    chk("t6_done",  {7'd0, done}, 8'd1);
    chk("t6_err",   {4'd0, err_count}, 8'd1);
    chk("t6_first", {5'd0, first_err_abc}, 8'd6);
    chk("t6_pass",  {7'd0, pass}, 8'd0);
    tick();
    start = 1'b0;
    chk("t6_restart_busy",  {7'd0, busy}, 8'd1);
    chk("t6_restart_err",   {4'd0, err_count}, 8'd0);
    chk("t6_restart_first", {5'd0, first_err_abc}, 8'd0);
    chk("t6_restart_cov",   coverage, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
